// File: rtl/rv64g_issue_scheduler_if.sv
// rv64g_issue_scheduler_if: scheduler bus (flush, input handshake with regs mask, register locks, output handshake, occupancy count); slave = scheduler, master = driver
interface rv64g_issue_scheduler_if #(parameter int NOS = 4, parameter int NR = 32, parameter int DW = 64);
  logic                       clear_i;
  logic [DW-1:0]              instr_in_i;
  logic [NR-1:0]              instr_in_regs_i;
  logic                       instr_in_valid_i;
  logic                       instr_in_ready_o;
  logic [NR-1:0]              locks_i;
  logic [DW-1:0]              instr_out_o;
  logic                       instr_out_valid_o;
  logic                       instr_out_ready_i;
  logic [$clog2(NOS+1)-1:0]   count_o;
  modport slave (
    input  clear_i, instr_in_i, instr_in_regs_i, instr_in_valid_i, locks_i, instr_out_ready_i,
    output instr_in_ready_o, instr_out_o, instr_out_valid_o, count_o
  );
  modport master (
    output clear_i, instr_in_i, instr_in_regs_i, instr_in_valid_i, locks_i, instr_out_ready_i,
    input  instr_in_ready_o, instr_out_o, instr_out_valid_o, count_o
  );
endinterface

// File: rtl/rv64g_issue_scheduler.sv
// rv64g_issue_scheduler: age-ordered slot buffer issuing the oldest hazard-free instruction; ports clk_i, rst_i (sync high) and bus (slave: flush, in/out valid-ready, locks, count)
module rv64g_issue_scheduler #(
  parameter int NOS = 4,
  parameter int NR  = 32,
  parameter int DW  = 64
) (
  input logic clk_i,
  input logic rst_i,
  rv64g_issue_scheduler_if.slave bus
);
  localparam int CW = $clog2(NOS+1);
  localparam int SW = $clog2(NOS);
  logic [DW-1:0] pay_q [NOS];
  logic [DW-1:0] pay_d [NOS];
  logic [NR-1:0] regs_q [NOS];
  logic [NR-1:0] regs_d [NOS];
  logic [CW-1:0] cnt_q, cnt_d, base;
  logic [NR-1:0] older;
  logic [SW-1:0] sel;
  logic found, issue, accept;
  always_comb begin
    older = '0;
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < NOS; k++)
      if (CW'(k) < cnt_q) begin
        if (!found && ~|(regs_q[k] & (bus.locks_i | older))) begin
          found = 1'b1;
          sel   = SW'(k);
        end
        older |= regs_q[k];
      end
  end
  assign bus.instr_out_valid_o = found && !bus.clear_i && !rst_i;
  assign bus.instr_out_o       = bus.instr_out_valid_o ? pay_q[sel] : '0;
  assign bus.instr_in_ready_o  = (cnt_q < CW'(NOS)) && !bus.clear_i && !rst_i;
  assign bus.count_o           = cnt_q;
  assign issue  = bus.instr_out_valid_o && bus.instr_out_ready_i;
  assign accept = bus.instr_in_valid_i && bus.instr_in_ready_o;
  assign base   = cnt_q - CW'(issue);
  assign cnt_d  = base + CW'(accept);
  always_comb begin
    for (int k = 0; k < NOS; k++) begin
      pay_d[k]  = (issue && k >= int'(sel)) ? pay_q[k < NOS-1 ? k+1 : k]  : pay_q[k];
      regs_d[k] = (issue && k >= int'(sel)) ? regs_q[k < NOS-1 ? k+1 : k] : regs_q[k];
      if (accept && CW'(k) == base) begin
        pay_d[k]  = bus.instr_in_i;
        regs_d[k] = bus.instr_in_regs_i;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    cnt_q  <= (rst_i || bus.clear_i) ? '0 : cnt_d;
    pay_q  <= pay_d;
    regs_q <= regs_d;
  end
endmodule
